// File: rtl/acc_aom_dac_sched.sv
// acc_aom_dac_sched: arbitrates ACC and PWM writes to the shared AOM DAC with ACC priority, hold window and clamping
module acc_aom_dac_sched #(
  parameter int DW         = 12,
  parameter int SETTLE_CYC = 4,
  parameter int HOLD_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              acc_req_i,
  input  logic [DW-1:0]     acc_level_i,
  input  logic [HOLD_W-1:0] acc_hold_i,
  input  logic              pwm_req_i,
  input  logic [DW-1:0]     pwm_level_i,
  input  logic [DW-1:0]     uplimit_i,
  input  logic [DW-1:0]     lowlimit_i,
  input  logic              dac_busy_i,
  output logic              dac_out_en_o,
  output logic [DW-1:0]     dac_out_o,
  output logic              acc_owner_o,
  output logic [7:0]        drop_cnt_o
);
  localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SC_LAST = CW'(SETTLE_CYC - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, SETTLE} state_t;
  state_t state, state_n;
  logic acc_full, pwm_full, first, go, take_acc, take_pwm, drop_a, drop_p;
  logic [DW-1:0] acc_lvl, pwm_lvl, sel_lvl, lo_v, clamped;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CW-1:0] cnt;
  logic [8:0] drop_sum;
  always_comb begin
    go       = state == IDLE && enable_i && (acc_full || (pwm_full && hold_cnt == '0));
    take_acc = go && acc_full;
    take_pwm = go && !acc_full;
    sel_lvl  = acc_full ? acc_lvl : pwm_lvl;
    lo_v     = sel_lvl < lowlimit_i ? lowlimit_i : sel_lvl;
    clamped  = lo_v > uplimit_i ? uplimit_i : lo_v;
    drop_a   = enable_i && acc_req_i && acc_full && !take_acc;
    drop_p   = enable_i && pwm_req_i && pwm_full && !take_pwm;
    drop_sum = {1'b0, drop_cnt_o} + 9'(drop_a) + 9'(drop_p);
    state_n  = state == IDLE      ? (go ? ISSUE : IDLE) :
               state == ISSUE     ? WAIT_BUSY :
               state == WAIT_BUSY ? (first || dac_busy_i ? WAIT_BUSY : SETTLE) :
                                    (cnt == SC_LAST ? IDLE : SETTLE);
  end
  assign dac_out_en_o = state == ISSUE;
  assign acc_owner_o  = hold_cnt != '0;
  // a request landing on the edge its slot is consumed refills the slot without counting a drop
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      first      <= 1'b0;
      cnt        <= '0;
      dac_out_o  <= '0;
      hold_cnt   <= '0;
      acc_full   <= 1'b0;
      pwm_full   <= 1'b0;
      acc_lvl    <= '0;
      pwm_lvl    <= '0;
      drop_cnt_o <= '0;
    end else begin
      state      <= state_n;
      first      <= state == ISSUE;
      cnt        <= state == SETTLE ? cnt + 1'b1 : '0;
      if (go) dac_out_o <= clamped;
      hold_cnt   <= !enable_i ? '0 : take_acc ? acc_hold_i : hold_cnt != '0 ? hold_cnt - 1'b1 : '0;
      acc_full   <= enable_i && (acc_req_i || (acc_full && !take_acc));
      pwm_full   <= enable_i && (pwm_req_i || (pwm_full && !take_pwm));
      if (acc_req_i) acc_lvl <= acc_level_i;
      if (pwm_req_i) pwm_lvl <= pwm_level_i;
      drop_cnt_o <= drop_sum > 9'd255 ? 8'hff : drop_sum[7:0];
    end
  end
endmodule

// File: tb/tb_acc_aom_dac_sched.sv
// tb_acc_aom_dac_sched: directed and randomized checks of the DAC scheduler against a timing-level reference model
module tb_acc_aom_dac_sched;
  localparam int SC = 4;
  logic clk = 0, rst_n = 0, enable = 0, acc_req = 0, pwm_req = 0, busy = 0;
  logic [11:0] acc_level = 0, pwm_level = 0, up = 12'hfff, low = 0;
  logic [31:0] acc_hold = 0;
  logic en_o, own_o;
  logic [11:0] out_o;
  logic [7:0] drop_o;
  int tests = 0, fails = 0, t = 0;
  bit m_a, m_p, m_en;
  int m_aval, m_pval, hold_end, free_t, m_out, m_drop, busy_left, busy_len, owner_cycles, k, d0, gap;
  int st_t[$], st_v[$];

  always #5 clk = ~clk;

  acc_aom_dac_sched dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
    .acc_req_i(acc_req), .acc_level_i(acc_level), .acc_hold_i(acc_hold),
    .pwm_req_i(pwm_req), .pwm_level_i(pwm_level),
    .uplimit_i(up), .lowlimit_i(low), .dac_busy_i(busy),
    .dac_out_en_o(en_o), .dac_out_o(out_o), .acc_owner_o(own_o), .drop_cnt_o(drop_o)
  );

  function automatic int clampf(int v, int lo, int hi);
    int x;
    x = v < lo ? lo : v;
    return x > hi ? hi : x;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_p = 0; hold_end = 0; free_t = 0; m_out = 0; m_drop = 0; busy_left = 0;
  endtask

  // One clock: reference model reacts to the edge, outputs are compared, busy and pulses are redriven.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
    m_en = 0;
    if (!rst_n) model_reset();
    else begin
      if (enable && t >= free_t && (m_a || (m_p && t > hold_end))) begin
        m_en = 1;
        if (m_a) begin
          m_out = clampf(m_aval, int'(low), int'(up));
          m_a = 0;
          hold_end = t + int'(acc_hold);
        end else begin
          m_out = clampf(m_pval, int'(low), int'(up));
          m_p = 0;
        end
        busy_left = busy_len;
        free_t = ((t + busy_len + 1 > t + 3) ? t + busy_len + 1 : t + 3) + SC + 1;
      end
      if (!enable) begin
        m_a = 0; m_p = 0;
        if (hold_end > t) hold_end = t;
      end else begin
        if (acc_req) begin
          if (m_a && m_drop < 255) m_drop++;
          m_a = 1; m_aval = int'(acc_level);
        end
        if (pwm_req) begin
          if (m_p && m_drop < 255) m_drop++;
          m_p = 1; m_pval = int'(pwm_level);
        end
      end
    end
    chk("strobe", en_o, m_en);
    chk("dac_out", out_o, m_out);
    chk("acc_owner", own_o, t < hold_end);
    chk("drop_cnt", drop_o, m_drop);
    if (en_o) begin st_t.push_back(t); st_v.push_back(int'(out_o)); end
    if (own_o) owner_cycles++;
    busy = busy_left > 0;
    if (busy_left > 0) busy_left--;
    acc_req = 0;
    pwm_req = 0;
  endtask

  task automatic run_until(int maxc);
    int n0;
    n0 = st_t.size();
    for (int i = 0; i < maxc && st_t.size() == n0; i++) step();
    chk("strobe_seen", st_t.size() > n0, 1);
  endtask

  initial begin
    model_reset();
    busy_len = 2;
    enable = 1;
    repeat (10) step();
    rst_n = 1;
    step();
    // 1: latency and plain write
    st_t.delete(); st_v.delete();
    acc_req = 1; acc_level = 2457; acc_hold = 0;
    step();
    k = t;
    step();
    chk("t1_strobe_count", st_t.size(), 1);
    chk("t1_latency", st_t.size() > 0 ? st_t[0] : -1, k + 1);
    chk("t1_level", out_o, 2457);
    repeat (16) step();
    // 2: clamping
    up = 2866;
    pwm_req = 1; pwm_level = 4095;
    run_until(20);
    chk("t2_clamp_hi", out_o, 2866);
    repeat (16) step();
    up = 4095; low = 819;
    pwm_req = 1; pwm_level = 0;
    run_until(20);
    chk("t2_clamp_lo", out_o, 819);
    repeat (16) step();
    up = 2000; low = 3000;
    pwm_req = 1; pwm_level = 100;
    run_until(20);
    chk("t2_up_wins", out_o, 2000);
    repeat (16) step();
    up = 4095; low = 0;
    // 3: ACC hold window blocks PWM
    st_t.delete(); st_v.delete();
    busy_len = 3; owner_cycles = 0;
    acc_req = 1; acc_level = 1638; acc_hold = 100;
    step();
    pwm_req = 1; pwm_level = 1000;
    repeat (140) step();
    chk("t3_strobes", st_t.size(), 2);
    chk("t3_acc_first", st_v.size() > 0 ? st_v[0] : -1, 1638);
    gap = st_t.size() == 2 ? st_t[1] - st_t[0] : -1;
    chk("t3_pwm_after_hold", gap >= 100, 1);
    chk("t3_owner_cycles", owner_cycles, 100);
    acc_hold = 0;
    // 4: overwrites while busy
    st_t.delete(); st_v.delete();
    d0 = int'(drop_o);
    busy_len = 20;
    acc_req = 1; acc_level = 500;
    step();
    repeat (3) step();
    pwm_req = 1; pwm_level = 700;
    repeat (2) step();
    pwm_req = 1; pwm_level = 800;
    repeat (2) step();
    pwm_req = 1; pwm_level = 900;
    busy_len = 2;
    repeat (40) step();
    chk("t4_drops", int'(drop_o) - d0, 2);
    chk("t4_strobes", st_t.size(), 2);
    chk("t4_last_level", st_v.size() == 2 ? st_v[1] : -1, 900);
    // 5: simultaneous requests
    st_t.delete(); st_v.delete();
    busy_len = 5;
    acc_req = 1; acc_level = 111; pwm_req = 1; pwm_level = 222;
    repeat (30) step();
    chk("t5_strobes", st_t.size(), 2);
    chk("t5_acc_first", st_v.size() == 2 ? st_v[0] : -1, 111);
    chk("t5_pwm_second", st_v.size() == 2 ? st_v[1] : -1, 222);
    gap = st_t.size() == 2 ? st_t[1] - st_t[0] : -1;
    chk("t5_gap", gap >= 5 + SC, 1);
    // 6a: asynchronous reset during WAIT_BUSY
    busy_len = 10;
    acc_req = 1; acc_level = 3000; acc_hold = 50;
    repeat (4) step();
    chk("t6_pre_out", out_o, 3000);
    rst_n = 0;
    #1;
    chk("t6_rst_en", en_o, 0);
    chk("t6_rst_out", out_o, 0);
    chk("t6_rst_owner", own_o, 0);
    chk("t6_rst_drop", drop_o, 0);
    repeat (3) step();
    rst_n = 1;
    acc_hold = 0;
    step();
    // 6b: disable mid-write, then re-enable
    st_t.delete(); st_v.delete();
    busy_len = 6;
    acc_req = 1; acc_level = 1234;
    repeat (2) step();
    enable = 0;
    for (int i = 0; i < 20; i++) begin
      pwm_req = 1; pwm_level = 12'(i);
      acc_req = i[0];
      step();
    end
    chk("t6_disabled_strobes", st_t.size(), 1);
    chk("t6_last_kept", out_o, 1234);
    enable = 1;
    pwm_req = 1; pwm_level = 77;
    repeat (15) step();
    chk("t6_reenable_strobes", st_t.size(), 2);
    chk("t6_reenable_level", out_o, 77);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      acc_req = $urandom_range(0, 5) == 0;
      pwm_req = $urandom_range(0, 3) == 0;
      acc_level = 12'($urandom);
      pwm_level = 12'($urandom);
      if ($urandom_range(0, 9) == 0) acc_hold = $urandom_range(0, 20);
      if ($urandom_range(0, 49) == 0) begin
        low = 12'($urandom);
        up = 12'($urandom);
      end
      if ($urandom_range(0, 199) == 0) enable = !enable;
      busy_len = $urandom_range(0, 8);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
